simd_wave_sequencer: RTL and testbench
======================================

# simd_wave_sequencer

Per-SIMD wave executor at the receiving end of the compute-unit dispatch handshake. Accepts one wavefront (start + wave_id) from the compute unit's wave dispatcher, derives the wave's base thread id and active-lane mask, then fetches, decodes and issues instructions to the SIMD lanes until a HALT instruction is decoded. It then raises done and holds it until the dispatcher withdraws start. One instance per SIMD; it holds at most one wave at a time.

## Interface
- WAVE_SIZE, 32, lanes per SIMD / threads per wave
- PC_WIDTH, 8, instruction address width
- INSTR_WIDTH, 16, instruction width; opcode is instr[INSTR_WIDTH-1 -: 4]
- HALT_OP, 4'hF, opcode that ends the wave
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  dispatcher has assigned a wave; held high until done is seen
- wave_id  in  32 signed  wave index within the block; valid while start is high
- block_id  in  32  0-based block index of this compute unit
- block_dim  in  32  threads per block (nonzero)
- num_threads  in  32  total kernel threads
- done  out  1  wave complete; held until start is low
- busy  out  1  high in every state except IDLE
- imem_req  out  1  instruction fetch request, level, held until imem_valid
- imem_addr  out  PC_WIDTH  fetch address (the current pc)
- imem_valid  in  1  fetch data valid
- imem_data  in  INSTR_WIDTH  fetched instruction
- issue_valid  out  1  one-cycle pulse: instruction issued to lanes
- issue_instr  out  INSTR_WIDTH  issued instruction
- issue_pc  out  PC_WIDTH  pc of issued instruction
- issue_mask  out  WAVE_SIZE  active lanes; bit k = lane k
- issue_base_tid  out  32  global thread id of lane 0
- lanes_done  in  1  lanes finished the issued instruction

## Operation
- FSM states: IDLE, SETUP, FETCH, ISSUE, WAIT_LANES, DONE.
- IDLE:
  - When start=1, latch wave_id, block_id, block_dim and num_threads.
  - Set pc=0 and go to SETUP.
- SETUP (1 cycle), all arithmetic 32-bit unsigned, registered:
  - block_base = block_id*block_dim.
  - block_threads = min(block_dim, num_threads - block_base); 0 if num_threads <= block_base.
  - wave_base = wave_id*WAVE_SIZE.
  - lanes = min(WAVE_SIZE, block_threads - wave_base); 0 if block_threads <= wave_base, or if wave_id is negative.
  - issue_mask = (1<<lanes)-1.
  - issue_base_tid = block_base + wave_base.
  - lanes=0 -> DONE (no fetch); otherwise -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc; remain in FETCH until imem_valid=1.
  - On imem_valid, capture imem_data.
  - If opcode==HALT_OP -> DONE. HALT is never issued.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle):
  - issue_valid=1; issue_instr and issue_pc are driven with the captured instruction and its pc.
  - Next state is WAIT_LANES.
- WAIT_LANES:
  - On lanes_done=1, pc <= pc+1 and go to FETCH.
  - pc wraps from 2^PC_WIDTH-1 to 0 silently.
- DONE:
  - done=1.
  - When start=0, go to IDLE and deassert done on the next cycle.
  - A new wave is never accepted while done=1.
- Ignored inputs:
  - imem_valid outside FETCH and lanes_done outside WAIT_LANES.
  - start falling before DONE: the wave runs to completion.
- issue_mask and issue_base_tid hold from SETUP until the next SETUP.

## Timing
- Reset values:
  - State IDLE; pc=0.
  - done, busy, imem_req, issue_valid all 0.
  - imem_addr, issue_instr, issue_pc, issue_mask, issue_base_tid all 0.
- Reset mid-operation: return to IDLE with the reset values on the next edge; any outstanding fetch or issue is abandoned.
- Cycle sequence with start sampled high in IDLE at cycle T:
  - T+1: SETUP, busy=1.
  - T+2: FETCH, imem_req=1.
  - Zero-wait memory (imem_valid in the same cycle as imem_req): ISSUE at T+3, WAIT_LANES at T+4.
  - HALT as the first instruction: done=1 at T+3.
  - lanes=0: done=1 at T+2.
- Per non-HALT instruction, minimum 3 cycles: FETCH, ISSUE, and WAIT_LANES with lanes_done already high.
- Done handshake:
  - done rises when DONE is entered.
  - Dispatcher drops start at cycle D; done is low at D+1.
  - Earliest next acceptance: start high at D+1, sampled in IDLE at D+1.
- All outputs are registered or decoded from the registered state; there is no combinational path from any input to any output.

## Test plan
- block_dim=64, num_threads=64, block_id=0, wave_id=1; program [ADD, HALT] -> issue_base_tid=32, issue_mask=32'hFFFFFFFF, exactly one issue_valid with issue_pc=0, done at the expected cycle, held until start=0, then low one cycle later.
- num_threads=40, block_dim=64, block_id=0, wave_id=1 -> lanes=8, issue_mask=32'h000000FF, issue_base_tid=32.
- num_threads=100, block_dim=64, block_id=1, wave_id=1 -> block_threads=36, wave_base=32, issue_mask=32'h0000000F, issue_base_tid=96.
- wave_id beyond the block (lanes=0) and wave_id=-1 -> no imem_req, done at T+2.
- imem_valid delayed 3 cycles and lanes_done delayed 5 cycles over a 3-instruction program -> imem_req and imem_addr held stable, issue_pc sequence 0, 1, 2, no spurious issue_valid.
- rst asserted while in WAIT_LANES -> all outputs at reset values next cycle; a fresh start runs normally. With PC_WIDTH=2 and a 4-instruction program without HALT, pc wraps to 0.

Source files
------------

// File: rtl/simd_wave_sequencer.sv
// simd_wave_sequencer: runs one wavefront on a SIMD.
// It takes a wave from the dispatcher, derives the wave's lane mask and base
// thread id, then loops fetch -> issue -> wait-for-lanes until HALT is fetched.
// Dispatcher handshake: start is held high until done is seen; done stays high
// until start drops, and done falls on the following cycle. A new wave is only
// accepted from IDLE, so the dispatcher cannot overlap two waves.
// All outputs come from registers or are decoded from the registered state.
module simd_wave_sequencer #(
   parameter int         WAVE_SIZE   = 32,
   parameter int         PC_WIDTH    = 8,
   parameter int         INSTR_WIDTH = 16,
   parameter logic [3:0] HALT_OP     = 4'hF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic signed [31:0]     wave_id,
   input  logic [31:0]            block_id,
   input  logic [31:0]            block_dim,
   input  logic [31:0]            num_threads,
   output logic                   done,
   output logic                   busy,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_valid,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic                   issue_valid,
   output logic [INSTR_WIDTH-1:0] issue_instr,
   output logic [PC_WIDTH-1:0]    issue_pc,
   output logic [WAVE_SIZE-1:0]   issue_mask,
   output logic [31:0]            issue_base_tid,
   input  logic                   lanes_done
);

   localparam logic [31:0] WS = 32'(WAVE_SIZE);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_FETCH, S_ISSUE, S_WAIT_LANES, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [31:0]            wave_id_q, wave_id_d;
   logic [31:0]            block_id_q, block_id_d;
   logic [31:0]            block_dim_q, block_dim_d;
   logic [31:0]            num_threads_q, num_threads_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [WAVE_SIZE-1:0]   mask_q, mask_d;
   logic [31:0]            base_q, base_d;

   logic [31:0] block_base, block_remain, block_threads;
   logic [31:0] wave_base, wave_remain, lanes;

   // Lane-count arithmetic on the latched wave parameters, consumed in SETUP.
   always_comb begin
      block_base   = block_id_q * block_dim_q;
      block_remain = num_threads_q - block_base;
      if (num_threads_q <= block_base) begin
         block_threads = '0;
      end else if (block_remain < block_dim_q) begin
         block_threads = block_remain;
      end else begin
         block_threads = block_dim_q;
      end
      wave_base   = wave_id_q * WS;
      wave_remain = block_threads - wave_base;
      // A negative wave_id (sign bit set) never owns lanes.
      if (wave_id_q[31] || (block_threads <= wave_base)) begin
         lanes = '0;
      end else if (wave_remain < WS) begin
         lanes = wave_remain;
      end else begin
         lanes = WS;
      end
   end

   // Next-state and datapath updates for the wave FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      wave_id_d     = wave_id_q;
      block_id_d    = block_id_q;
      block_dim_d   = block_dim_q;
      num_threads_d = num_threads_q;
      instr_d       = instr_q;
      mask_d        = mask_q;
      base_d        = base_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               wave_id_d     = wave_id;
               block_id_d    = block_id;
               block_dim_d   = block_dim;
               num_threads_d = num_threads;
               pc_d          = '0;
               state_d       = S_SETUP;
            end
         end
         S_SETUP: begin
            // A shift of WAVE_SIZE or more clears all bits, so lanes==WAVE_SIZE
            // yields an all-ones mask.
            mask_d  = ~({WAVE_SIZE{1'b1}} << lanes);
            base_d  = block_base + wave_base;
            state_d = (lanes == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            if (imem_valid) begin
               instr_d = imem_data;
               state_d = (imem_data[INSTR_WIDTH-1 -: 4] == HALT_OP) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_LANES;
         end
         S_WAIT_LANES: begin
            if (lanes_done) begin
               pc_d    = pc_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         wave_id_q     <= '0;
         block_id_q    <= '0;
         block_dim_q   <= '0;
         num_threads_q <= '0;
         instr_q       <= '0;
         mask_q        <= '0;
         base_q        <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         wave_id_q     <= wave_id_d;
         block_id_q    <= block_id_d;
         block_dim_q   <= block_dim_d;
         num_threads_q <= num_threads_d;
         instr_q       <= instr_d;
         mask_q        <= mask_d;
         base_q        <= base_d;
      end
   end

   assign done           = (state_q == S_DONE);
   assign busy           = (state_q != S_IDLE);
   assign imem_req       = (state_q == S_FETCH);
   assign issue_valid    = (state_q == S_ISSUE);
   assign imem_addr      = pc_q;
   assign issue_pc       = pc_q;
   assign issue_instr    = instr_q;
   assign issue_mask     = mask_q;
   assign issue_base_tid = base_q;

endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Directed bench for simd_wave_sequencer: main instance with default widths plus
// a PC_WIDTH=2 instance running a HALT-free program to show pc wrap-around.
module tb_simd_wave_sequencer;

   logic               clk, rst, start;
   logic signed [31:0] wave_id;
   logic [31:0]        block_id, block_dim, num_threads;

   logic        done, busy, imem_req, imem_valid, issue_valid, lanes_done;
   logic [7:0]  imem_addr, issue_pc;
   logic [15:0] imem_data, issue_instr;
   logic [31:0] issue_mask, issue_base_tid;

   logic        done2, busy2, imem_req2, issue_valid2;
   logic [1:0]  imem_addr2, issue_pc2;
   logic [15:0] imem_data2, issue_instr2;
   logic [31:0] issue_mask2, issue_base_tid2;

   logic [15:0] prog [0:255];
   int mem_delay, lanes_delay, req_cnt, lane_cnt;
   int n_checks, n_errors;
   logic [7:0] exp_q[$];
   logic [1:0] pc2_q[$];

   simd_wave_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start), .wave_id(wave_id), .block_id(block_id),
      .block_dim(block_dim), .num_threads(num_threads), .done(done), .busy(busy),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_data(imem_data), .issue_valid(issue_valid), .issue_instr(issue_instr),
      .issue_pc(issue_pc), .issue_mask(issue_mask), .issue_base_tid(issue_base_tid),
      .lanes_done(lanes_done)
   );

   simd_wave_sequencer #(.PC_WIDTH(2)) u_dut_wrap (
      .clk(clk), .rst(rst), .start(start), .wave_id(wave_id), .block_id(block_id),
      .block_dim(block_dim), .num_threads(num_threads), .done(done2), .busy(busy2),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_valid(imem_req2),
      .imem_data(imem_data2), .issue_valid(issue_valid2), .issue_instr(issue_instr2),
      .issue_pc(issue_pc2), .issue_mask(issue_mask2), .issue_base_tid(issue_base_tid2),
      .lanes_done(1'b1)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Memory and lane responders with programmable latency
   assign imem_data  = prog[imem_addr];
   assign imem_data2 = {14'h0400, imem_addr2};
   assign imem_valid = imem_req && (req_cnt >= mem_delay);
   assign lanes_done = (lane_cnt >= lanes_delay);

   always @(posedge clk) begin
      req_cnt  <= imem_req ? req_cnt + 1 : 0;
      lane_cnt <= issue_valid ? 0 : ((lane_cnt >= 1000) ? 1000 : lane_cnt + 1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Scoreboard: every issue of the main instance must match the next expected pc
   always @(negedge clk) begin
      if (!rst && issue_valid) begin
         if (exp_q.size() == 0) chk("spurious_issue", 32'd1, 32'd0);
         else chk("issue_pc", {24'd0, issue_pc}, {24'd0, exp_q.pop_front()});
      end
      if (!rst && issue_valid2) pc2_q.push_back(issue_pc2);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
   endtask

   task automatic start_wave(input int wid, input logic [31:0] bid,
                             input logic [31:0] bdim, input logic [31:0] nt);
      wave_id     = wid;
      block_id    = bid;
      block_dim   = bdim;
      num_threads = nt;
      start       = 1'b1;
   endtask

   // Drop start after done and confirm the handshake release timing.
   task automatic finish_wave(input string tag);
      chk({tag, "_done_before_drop"}, {31'd0, done}, 32'd1);
      start = 1'b0;
      tick();
      chk({tag, "_done_after_drop"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy_after_drop"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_done(input string tag, input int exp_cyc);
      int cyc;
      logic prev_req, prev_valid;
      logic [7:0] prev_addr;
      cyc = 0;
      while (!done && cyc < 300) begin
         prev_req   = imem_req;
         prev_valid = imem_valid;
         prev_addr  = imem_addr;
         tick();
         cyc++;
         if (prev_req && !prev_valid) begin
            chk({tag, "_req_held"}, {31'd0, imem_req}, 32'd1);
            chk({tag, "_addr_held"}, {24'd0, imem_addr}, {24'd0, prev_addr});
         end
      end
      chk({tag, "_done_cycle"}, cyc, exp_cyc);
      chk({tag, "_issues_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b1; start = 1'b0;
      wave_id = 0; block_id = 0; block_dim = 0; num_threads = 0;
      mem_delay = 0; lanes_delay = 0;
      clear_prog();
      repeat (3) tick();

      // Reset values
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_mask", issue_mask, 32'd0);
      chk("rst_base", issue_base_tid, 32'd0);
      rst = 1'b0;
      tick();

      // Full wave, program [ADD, HALT], zero-wait memory and lanes
      prog[0] = 16'h1234; prog[1] = 16'hF000;
      exp_q.push_back(8'd0);
      start_wave(1, 0, 64, 64);
      tick();
      chk("t1_setup_busy", {31'd0, busy}, 32'd1);
      chk("t1_setup_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t1_fetch_req", {31'd0, imem_req}, 32'd1);
      chk("t1_fetch_addr", {24'd0, imem_addr}, 32'd0);
      chk("t1_mask", issue_mask, 32'hFFFF_FFFF);
      chk("t1_base", issue_base_tid, 32'd32);
      tick();
      chk("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
      chk("t1_issue_instr", {16'd0, issue_instr}, 32'h1234);
      tick();
      chk("t1_wait_valid", {31'd0, issue_valid}, 32'd0);
      chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t1_fetch2_addr", {24'd0, imem_addr}, 32'd1);
      chk("t1_fetch2_done", {31'd0, done}, 32'd0);
      tick();
      chk("t1_done", {31'd0, done}, 32'd1);
      repeat (3) tick();
      chk("t1_done_held", {31'd0, done}, 32'd1);
      chk("t1_no_issue_left", exp_q.size(), 32'd0);
      finish_wave("t1");
      chk("t1_mask_held_idle", issue_mask, 32'hFFFF_FFFF);

      // Partial waves with HALT as first instruction
      clear_prog();
      prog[0] = 16'hF000;
      start_wave(1, 0, 64, 40);
      tick(); tick();
      chk("t2_mask", issue_mask, 32'h0000_00FF);
      chk("t2_base", issue_base_tid, 32'd32);
      tick();
      chk("t2_done_halt", {31'd0, done}, 32'd1);
      finish_wave("t2");

      start_wave(1, 1, 64, 100);
      tick(); tick();
      chk("t3_mask", issue_mask, 32'h0000_000F);
      chk("t3_base", issue_base_tid, 32'd96);
      tick();
      chk("t3_done_halt", {31'd0, done}, 32'd1);
      finish_wave("t3");

      // Waves with no lanes: beyond the block, and negative wave_id
      start_wave(2, 0, 64, 64);
      tick();
      chk("t4_setup_done", {31'd0, done}, 32'd0);
      tick();
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_no_req", {31'd0, imem_req}, 32'd0);
      chk("t4_mask", issue_mask, 32'd0);
      finish_wave("t4");

      start_wave(-1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      chk("t5_setup_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_no_req", {31'd0, imem_req}, 32'd0);
      chk("t5_mask", issue_mask, 32'd0);
      finish_wave("t5");

      // Slow memory and slow lanes over a 3-instruction program
      clear_prog();
      prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'h3003; prog[3] = 16'hF000;
      exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
      mem_delay = 3; lanes_delay = 5;
      start_wave(1, 0, 64, 64);
      wait_done("t6", 39);
      finish_wave("t6");
      mem_delay = 0; lanes_delay = 0;

      // Reset while waiting on lanes, then a fresh wave
      clear_prog();
      prog[0] = 16'h1001; prog[1] = 16'hF000;
      lanes_delay = 50;
      exp_q.push_back(8'd0);
      start_wave(0, 0, 64, 64);
      repeat (4) tick();
      chk("t7_in_wait_busy", {31'd0, busy}, 32'd1);
      chk("t7_in_wait_req", {31'd0, imem_req}, 32'd0);
      rst = 1'b1;
      tick();
      chk("t7_rst_busy", {31'd0, busy}, 32'd0);
      chk("t7_rst_done", {31'd0, done}, 32'd0);
      chk("t7_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t7_rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      chk("t7_rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("t7_rst_instr", {16'd0, issue_instr}, 32'd0);
      chk("t7_rst_pc", {24'd0, issue_pc}, 32'd0);
      chk("t7_rst_mask", issue_mask, 32'd0);
      chk("t7_rst_base", issue_base_tid, 32'd0);
      rst = 1'b0;
      lanes_delay = 0;
      exp_q.push_back(8'd0);
      wait_done("t7_fresh", 6);
      finish_wave("t7");

      // pc wrap on the 2-bit-pc instance (program never halts)
      rst = 1'b1;
      tick();
      pc2_q.delete();
      rst = 1'b0;
      clear_prog();
      prog[0] = 16'hF000;
      start_wave(0, 0, 64, 64);
      repeat (20) tick();
      chk("t8_wrap_count", pc2_q.size(), 32'd6);
      for (int i = 0; i < pc2_q.size() && i < 6; i++) begin
         chk("t8_wrap_pc", {30'd0, pc2_q[i]}, i % 4);
      end
      chk("t8_wrap_busy", {31'd0, busy2}, 32'd1);
      finish_wave("t8");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
